// File: rtl/demux_select_sequencer_pkg.sv
// Shared definitions for the demux select sequencer: debounce FSM states,
// channel sizing and the channel-advance helper.
package demux_select_sequencer_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int CH_W         = $clog2(NUM_CHANNELS);

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } deb_state_t;

  // NUM_CHANNELS is a power of two, so the natural wrap gives 3 -> 0.
  function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0] ch);
    return CH_W'(ch + 1'b1);
  endfunction

endpackage

// File: rtl/demux_select_sequencer_debounce_filter.sv
// Two-flop button synchroniser plus a four-state debounce FSM; o_press is
// high for the single cycle on which a press is committed.
module debounce_filter
  import demux_select_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [1:0]       sync_reg;
  logic             btn_s;
  deb_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], i_button};
    end
  end

  assign btn_s = sync_reg[1];

  // cnt counts consecutive cycles of the new level, including the entry cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_RELEASED;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_RELEASED: begin
          if (btn_s) begin
            state_reg <= S_PRESS_CHK;
            cnt_reg   <= CNT_W'(1);
          end
        end
        S_PRESS_CHK: begin
          if (!btn_s) begin
            state_reg <= S_RELEASED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= S_PRESSED;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!btn_s) begin
            state_reg <= S_RELEASE_CHK;
            cnt_reg   <= CNT_W'(1);
          end
        end
        S_RELEASE_CHK: begin
          if (btn_s) begin
            state_reg <= S_PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= S_RELEASED;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_RELEASED;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Decoded from registers only, so the top can act on the same edge the FSM commits.
  assign o_press = (state_reg == S_PRESS_CHK) && btn_s && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/demux_select_sequencer.sv
// Drives the 1-to-4 demux: debounced button steps the selected channel, and
// the data bit blinks so only the selected output toggles.
module demux_select_sequencer
  import demux_select_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT    = 250000,
  parameter int BLINK_HALF_PERIOD = 12500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  input  logic i_blink_en,
  output logic o_data,
  output logic o_sel_1,
  output logic o_sel_2,
  output logic o_channel_pulse
);

  localparam int                 BLINK_W    = $clog2(BLINK_HALF_PERIOD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);

  if (DEBOUNCE_LIMIT < 2 || BLINK_HALF_PERIOD < 2) begin : g_bad_params
    $error("demux_select_sequencer: DEBOUNCE_LIMIT and BLINK_HALF_PERIOD must be >= 2");
  end

  logic               press;
  logic [CH_W-1:0]    channel_reg;
  logic               pulse_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               data_reg;

  debounce_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_button(i_button),
    .o_press (press)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      channel_reg <= '0;
      pulse_reg   <= 1'b0;
    end else begin
      pulse_reg <= press;
      if (press) begin
        channel_reg <= next_channel(channel_reg);
      end
    end
  end

  // A committed press takes priority over the blink terminal count so the
  // newly selected channel always starts lit with a full half-period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_reg <= '0;
      data_reg      <= 1'b0;
    end else if (press || !i_blink_en) begin
      blink_cnt_reg <= '0;
      data_reg      <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      data_reg      <= ~data_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  assign o_data          = data_reg;
  assign o_sel_1         = channel_reg[1];
  assign o_sel_2         = channel_reg[0];
  assign o_channel_pulse = pulse_reg;

endmodule
